// File: rtl/idma_obi_wr_arbiter_pkg.sv
// Shared types and helpers for the iDMA OBI write-port arbiter.
package idma_obi_arb_pkg;

  // Lock state of the A-channel arbiter: IDLE picks round-robin, LOCKED holds
  // the previously selected requester until the bus grants it.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  // Width of a fill-level counter able to hold 0..max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return $clog2(max_count + 1);
  endfunction

  // Width of a requester index; at least one bit.
  function automatic int unsigned idx_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/idma_obi_wr_arbiter_fifo.sv
// In-order ID FIFO (registered output, no fall-through) that remembers which
// requester issued each outstanding write.
module idma_obi_wr_arbiter_fifo
  import idma_obi_arb_pkg::*;
#(
  parameter int unsigned DataWidth = 1,
  parameter int unsigned Depth     = 4,
  localparam int unsigned CntW     = cnt_width(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 i_push,
  input  logic [DataWidth-1:0] i_data,
  input  logic                 i_pop,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CntW-1:0]      o_count
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_wr_ptr;
  logic [PtrW-1:0]      r_rd_ptr;
  logic [CntW-1:0]      r_count;
  logic                 w_push;
  logic                 w_pop;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full  = (r_count == CntW'(Depth));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // Storage array: written on push, no reset needed since count gates reads.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and fill-level bookkeeping; push and pop together keep the count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/idma_obi_wr_arbiter.sv
// Shares one OBI write manager port among NumReq iDMA write backends.
// Round-robin A-channel arbitration with grant lock, in-order response routing.
//
// Handshake rules: an A transfer happens in the cycle m_req_o & m_gnt_i; once
// m_req_o is raised for a requester its payload is held (LOCKED) until that
// transfer. An R transfer happens in the cycle m_rvalid_i & m_rready_o and is
// routed to the requester at the head of the ID FIFO.
module idma_obi_wr_arbiter
  import idma_obi_arb_pkg::*;
#(
  parameter int unsigned NumReq         = 2,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 1,
  localparam int unsigned BeWidth       = DataWidth / 8,
  localparam int unsigned IdxW          = idx_width(NumReq),
  localparam int unsigned CntW          = cnt_width(MaxOutstanding)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              s_req_i,
  output logic [NumReq-1:0]              s_gnt_o,
  input  logic [NumReq*AddrWidth-1:0]    s_addr_i,
  input  logic [NumReq*BeWidth-1:0]      s_be_i,
  input  logic [NumReq*DataWidth-1:0]    s_wdata_i,
  input  logic [NumReq*IdWidth-1:0]      s_aid_i,
  output logic [NumReq-1:0]              s_rvalid_o,
  input  logic [NumReq-1:0]              s_rready_i,
  output logic                           m_req_o,
  input  logic                           m_gnt_i,
  output logic                           m_we_o,
  output logic [AddrWidth-1:0]           m_addr_o,
  output logic [BeWidth-1:0]             m_be_o,
  output logic [DataWidth-1:0]           m_wdata_o,
  output logic [IdWidth-1:0]             m_aid_o,
  input  logic                           m_rvalid_i,
  output logic                           m_rready_o,
  output logic [CntW-1:0]                outstanding_o,
  output logic                           err_o,
  output lock_state_e                    dbg_state_o
);

  typedef logic [IdxW-1:0] idx_t;
  typedef logic [CntW-1:0] cnt_t;

  lock_state_e r_state;
  lock_state_e w_state_nxt;
  idx_t        r_lock_idx;
  idx_t        w_lock_idx_nxt;
  idx_t        r_rr_ptr;
  idx_t        w_sel;
  idx_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_req;
  logic        w_hs;
  logic        w_rready;
  logic        w_pop;
  logic        r_err;
  cnt_t        w_count;

  // First requesting index at or after ptr, searching cyclically.
  function automatic idx_t rr_pick(input logic [NumReq-1:0] req, input idx_t ptr);
    idx_t        pick;
    logic        found;
    int unsigned c;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      c = 32'(ptr) + i;
      if (c >= NumReq) c = c - NumReq;
      if (!found && req[idx_t'(c)]) begin
        pick  = idx_t'(c);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic idx_t idx_inc(input idx_t idx);
    return (idx == idx_t'(NumReq - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Selection: locked index holds, otherwise round-robin. Full blocks forwarding
  // using registered fill level only, so a same-cycle pop never frees a slot.
  // Outputs are forced to reset values while rst_i is high.
  always_comb begin
    w_sel = (r_state == LOCKED) ? r_lock_idx : rr_pick(s_req_i, r_rr_ptr);
    w_req = ~rst_i & ~w_full & s_req_i[w_sel];
    w_hs  = w_req & m_gnt_i;
  end

  // Lock FSM next state: lock when a forwarded request is not granted at once.
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_idx_nxt = r_lock_idx;
    case (r_state)
      IDLE: begin
        if (w_req && !m_gnt_i) begin
          w_state_nxt    = LOCKED;
          w_lock_idx_nxt = w_sel;
        end
      end
      LOCKED: begin
        if (w_hs) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Lock FSM state, round-robin pointer and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_lock_idx <= '0;
      r_rr_ptr   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_idx <= w_lock_idx_nxt;
      if (w_hs) r_rr_ptr <= idx_inc(w_sel);
      if (m_rvalid_i && w_empty) r_err <= 1'b1;
    end
  end

  // A-channel mux: payload of the selected requester, zero when not requesting.
  always_comb begin
    m_addr_o  = '0;
    m_be_o    = '0;
    m_wdata_o = '0;
    m_aid_o   = '0;
    s_gnt_o   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (w_req && (w_sel == idx_t'(i))) begin
        m_addr_o   = s_addr_i[i*AddrWidth +: AddrWidth];
        m_be_o     = s_be_i[i*BeWidth +: BeWidth];
        m_wdata_o  = s_wdata_i[i*DataWidth +: DataWidth];
        m_aid_o    = s_aid_i[i*IdWidth +: IdWidth];
        s_gnt_o[i] = m_gnt_i;
      end
    end
  end

  // R-channel routing to the FIFO head; an unexpected response is drained.
  always_comb begin
    s_rvalid_o = '0;
    w_rready   = w_empty ? m_rvalid_i : 1'b0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_empty && (w_head == idx_t'(i))) begin
        s_rvalid_o[i] = m_rvalid_i & ~rst_i;
        w_rready      = s_rready_i[i];
      end
    end
    m_rready_o = w_rready & ~rst_i;
    w_pop      = m_rvalid_i & m_rready_o & ~w_empty;
  end

  idma_obi_wr_arbiter_fifo #(
    .DataWidth (IdxW),
    .Depth     (MaxOutstanding)
  ) i_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_push  (w_hs),
    .i_data  (w_sel),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign m_req_o       = w_req;
  assign m_we_o        = 1'b1;
  assign outstanding_o = w_count;
  assign err_o         = r_err;
  assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_idma_obi_wr_arbiter.sv
// Directed bench for idma_obi_wr_arbiter: grant and response scoreboards fed
// by the stimulus, checked by an independent negedge monitor.
module tb_idma_obi_wr_arbiter;
  import idma_obi_arb_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;
  localparam int unsigned IW = 1;
  localparam int unsigned GW = 1 + AW + DW + BW + IW;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     s_req;
  logic [NR-1:0]     s_gnt;
  logic [NR*AW-1:0]  s_addr;
  logic [NR*BW-1:0]  s_be;
  logic [NR*DW-1:0]  s_wdata;
  logic [NR*IW-1:0]  s_aid;
  logic [NR-1:0]     s_rvalid;
  logic [NR-1:0]     s_rready;
  logic              m_req;
  logic              m_gnt;
  logic              m_we;
  logic [AW-1:0]     m_addr;
  logic [BW-1:0]     m_be;
  logic [DW-1:0]     m_wdata;
  logic [IW-1:0]     m_aid;
  logic              m_rvalid;
  logic              m_rready;
  logic [2:0]        outstanding;
  logic              err;
  lock_state_e       dbg_state;

  logic              auto_rsp;
  logic              man_rvalid;
  logic              hs_n;
  logic              d0;
  logic              d1;

  logic [AW-1:0]     addr_v  [NR];
  logic [DW-1:0]     wdata_v [NR];
  logic [BW-1:0]     be_v    [NR];
  logic [IW-1:0]     aid_v   [NR];

  logic [GW-1:0]     exp_q     [$];
  logic [0:0]        exp_rsp_q [$];

  int total;
  int bad;

  idma_obi_wr_arbiter #(
    .NumReq(NR), .MaxOutstanding(4), .AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_req_i(s_req), .s_gnt_o(s_gnt), .s_addr_i(s_addr), .s_be_i(s_be),
    .s_wdata_i(s_wdata), .s_aid_i(s_aid), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
    .m_req_o(m_req), .m_gnt_i(m_gnt), .m_we_o(m_we), .m_addr_o(m_addr), .m_be_o(m_be),
    .m_wdata_o(m_wdata), .m_aid_o(m_aid), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready),
    .outstanding_o(outstanding), .err_o(err), .dbg_state_o(dbg_state)
  );

  // Clock and response generator (rvalid two cycles after each handshake).
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    d0 <= hs_n;
    d1 <= d0;
  end

  assign m_rvalid = auto_rsp ? d1 : man_rvalid;
  assign s_addr   = {addr_v[1], addr_v[0]};
  assign s_wdata  = {wdata_v[1], wdata_v[0]};
  assign s_be     = {be_v[1], be_v[0]};
  assign s_aid    = {aid_v[1], aid_v[0]};

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Driver helpers.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_gnt(input int i);
    exp_q.push_back({1'(i), addr_v[i], wdata_v[i], be_v[i], aid_v[i]});
  endtask

  task automatic push_rsp(input int i);
    exp_rsp_q.push_back(1'(i));
  endtask

  // Monitor: pops expectations whenever the DUT presents a handshake.
  initial begin
    logic [GW-1:0] exp_g;
    logic [0:0]    exp_r;
    hs_n = 1'b0;
    forever begin
      @(negedge clk);
      hs_n = m_req & m_gnt;
      if (!rst && m_req && m_gnt) begin
        check("gnt_onehot", 128'(s_gnt == 2'b01 || s_gnt == 2'b10), 128'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 128'(s_gnt), 128'd0);
        end else begin
          exp_g = exp_q.pop_front();
          check("grant", 128'({s_gnt[1], m_addr, m_wdata, m_be, m_aid}), 128'(exp_g));
        end
      end
      if (!rst && m_rvalid && m_rready && (s_rvalid != '0)) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_rsp", 128'(s_rvalid), 128'd0);
        end else begin
          exp_r = exp_rsp_q.pop_front();
          check("rsp_route", 128'(s_rvalid), (exp_r == 1'b1) ? 128'd2 : 128'd1);
        end
      end
      if (!rst && auto_rsp) check("outstanding_le2", 128'(outstanding <= 3'd2), 128'd1);
    end
  end

  // Directed stimulus.
  initial begin
    total = 0;
    bad   = 0;
    addr_v[0]  = 32'h1000_0A00;  addr_v[1]  = 32'h2000_0B00;
    wdata_v[0] = 32'hCAFE_0000;  wdata_v[1] = 32'hBEEF_1111;
    be_v[0]    = 4'h3;           be_v[1]    = 4'hC;
    aid_v[0]   = 1'b0;           aid_v[1]   = 1'b1;
    auto_rsp = 1'b0; man_rvalid = 1'b1;
    rst = 1'b1; s_req = 2'b11; m_gnt = 1'b1; s_rready = 2'b11;

    // Reset values, with requests and rvalid active to prove gating.
    cyc(1);
    check("rst_m_req", 128'(m_req), 128'd0);
    check("rst_s_gnt", 128'(s_gnt), 128'd0);
    check("rst_s_rvalid", 128'(s_rvalid), 128'd0);
    check("rst_m_rready", 128'(m_rready), 128'd0);
    check("rst_outstanding", 128'(outstanding), 128'd0);
    check("rst_err", 128'(err), 128'd0);
    check("rst_state", 128'(dbg_state), 128'(IDLE));
    check("we_const", 128'(m_we), 128'd1);
    s_req = '0; m_gnt = 1'b0; man_rvalid = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Test 1: both requesting, gnt every cycle, auto responses.
    auto_rsp = 1'b1;
    s_req = 2'b11; m_gnt = 1'b1;
    push_gnt(0); push_gnt(1); push_gnt(0); push_gnt(1);
    push_rsp(0); push_rsp(1); push_rsp(0); push_rsp(1);
    cyc(4);
    s_req = '0; m_gnt = 1'b0;
    cyc(4);
    @(negedge clk);
    check("t1_drained", 128'(outstanding), 128'd0);
    cyc(1);

    // Test 2: lock holds requester 0 while requester 1 joins (ptr at 1).
    s_req = 2'b01; m_gnt = 1'b1; push_gnt(0); push_rsp(0);
    cyc(1);
    m_gnt = 1'b0;
    @(negedge clk);
    check("t2_addr_c0", 128'(m_addr), 128'(addr_v[0]));
    check("t2_no_gnt", 128'(s_gnt), 128'd0);
    cyc(1);
    s_req = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t2_addr_locked", 128'(m_addr), 128'(addr_v[0]));
      check("t2_state_locked", 128'(dbg_state), 128'(LOCKED));
      cyc(1);
    end
    m_gnt = 1'b1;
    push_gnt(0); push_gnt(1); push_rsp(0); push_rsp(1);
    cyc(2);
    s_req = '0; m_gnt = 1'b0;
    cyc(4);
    @(negedge clk);
    check("t2_drained", 128'(outstanding), 128'd0);
    cyc(1);

    // Test 3: no responses, continuous grants -> exactly four handshakes.
    auto_rsp = 1'b0; man_rvalid = 1'b0;
    s_req = 2'b11; m_gnt = 1'b1;
    push_gnt(0); push_gnt(1); push_gnt(0); push_gnt(1);
    cyc(5);
    @(negedge clk);
    check("t3_full_req", 128'(m_req), 128'd0);
    check("t3_full_cnt", 128'(outstanding), 128'd4);
    check("t3_full_payload", 128'(m_addr), 128'd0);
    cyc(1);
    man_rvalid = 1'b1; push_rsp(0);
    @(negedge clk);
    check("t3_pop_no_push", 128'(m_req), 128'd0);
    check("t3_rvalid_route", 128'(s_rvalid), 128'd1);
    cyc(1);
    man_rvalid = 1'b0; push_gnt(0);
    @(negedge clk);
    check("t3_cnt3", 128'(outstanding), 128'd3);
    cyc(1);
    s_req = '0; m_gnt = 1'b0;
    @(negedge clk);
    check("t3_cnt4", 128'(outstanding), 128'd4);
    cyc(1);

    // Test 4: head is requester 1 and it stalls rready for two cycles.
    man_rvalid = 1'b1; s_rready = 2'b01;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("t4_rready_low", 128'(m_rready), 128'd0);
      check("t4_rvalid_head1", 128'(s_rvalid), 128'd2);
      check("t4_cnt_hold", 128'(outstanding), 128'd4);
      cyc(1);
    end
    s_rready = 2'b11;
    push_rsp(1); push_rsp(0); push_rsp(1); push_rsp(0);
    cyc(4);
    man_rvalid = 1'b0;
    @(negedge clk);
    check("t4_drained", 128'(outstanding), 128'd0);
    check("t4_no_err", 128'(err), 128'd0);
    cyc(1);

    // Test 5: response with an empty FIFO is drained and flags err.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    man_rvalid = 1'b1;
    @(negedge clk);
    check("t5_drain_rready", 128'(m_rready), 128'd1);
    check("t5_no_route", 128'(s_rvalid), 128'd0);
    cyc(1);
    man_rvalid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t5_err_sticky", 128'(err), 128'd1);
      cyc(1);
    end
    rst = 1'b1;
    #1;
    check("t5_err_cleared", 128'(err), 128'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Test 6: asynchronous reset with three writes outstanding.
    s_req = 2'b01; m_gnt = 1'b1;
    push_gnt(0); push_gnt(0); push_gnt(0);
    cyc(3);
    check("t6_cnt3", 128'(outstanding), 128'd3);
    s_req = 2'b11; m_gnt = 1'b0; man_rvalid = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t6_m_req", 128'(m_req), 128'd0);
    check("t6_s_gnt", 128'(s_gnt), 128'd0);
    check("t6_s_rvalid", 128'(s_rvalid), 128'd0);
    check("t6_m_rready", 128'(m_rready), 128'd0);
    check("t6_cnt0", 128'(outstanding), 128'd0);
    check("t6_state", 128'(dbg_state), 128'(IDLE));
    man_rvalid = 1'b0; s_req = '0;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_cnt_release", 128'(outstanding), 128'd0);
    cyc(1);
    man_rvalid = 1'b1;
    cyc(1);
    man_rvalid = 1'b0;
    @(negedge clk);
    check("t6_late_rvalid_err", 128'(err), 128'd1);
    cyc(1);

    check("gnt_queue_empty", 128'(exp_q.size()), 128'd0);
    check("rsp_queue_empty", 128'(exp_rsp_q.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
